sm4_round_core: RTL and testbench

Iterative SM4 data-path core that consumes the 1024-bit round-key bus produced by the SM4 key-expansion block and encrypts or decrypts one 128-bit block per operation. It runs one round per clock, 32 rounds per block, behind valid/ready handshakes on both input and output. It sits between the key-expansion block and the system's block-level data interface. Decryption uses the same keys in reverse order.

---
 rtl/sm4_pkg.sv | 46 ++++
 rtl/sm4_tau.sv | 17 +
 rtl/sm4_round_core.sv | 118 +++++++++++
 tb/tb_sm4_round_core.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// ---------------------------------------------------------------------------
// sm4_pkg
//   Definitions shared by the SM4 data path and the key-expansion path:
//   the FSM state encoding, the round count, the 8-bit S-box and the
//   data-path linear transform L.
// ---------------------------------------------------------------------------
package sm4_pkg;

   typedef logic [1:0] sm4_state_t;

   localparam sm4_state_t ST_IDLE = 2'd0;
   localparam sm4_state_t ST_RUN  = 2'd1;
   localparam sm4_state_t ST_DONE = 2'd2;

   localparam int SM4_ROUNDS = 32;

   localparam logic [7:0] SM4_SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   function automatic logic [7:0] sm4_sbox_byte(input logic [7:0] b);
      return SM4_SBOX[b];
   endfunction

   // L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24
   function automatic logic [31:0] sm4_l(input logic [31:0] b);
      return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
               ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
   endfunction

endpackage

// File: rtl/sm4_tau.sv
// ---------------------------------------------------------------------------
// sm4_tau
//   Non-linear substitution tau: the SM4 S-box applied to each byte of a word.
//   tau_in  [31:0]  input word
//   tau_out [31:0]  substituted word
// ---------------------------------------------------------------------------
module sm4_tau
   import sm4_pkg::*;
(
   input  logic [31:0] tau_in,
   output logic [31:0] tau_out
);

   assign tau_out = {sm4_sbox_byte(tau_in[31:24]), sm4_sbox_byte(tau_in[23:16]),
                     sm4_sbox_byte(tau_in[15:8]),  sm4_sbox_byte(tau_in[7:0])};

endmodule

// File: rtl/sm4_round_core.sv
// ---------------------------------------------------------------------------
// sm4_round_core
//   Iterative SM4 encrypt/decrypt data path, one round per clock, 32 rounds
//   per 128-bit block, valid/ready on input and output.
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   rk         round keys, rk0 in [1023:992] .. rk31 in [31:0]; held stable
//              from accept until the output handshake
//   mode       0 = encrypt, 1 = decrypt (sampled on accept)
//   din        input block {X0,X1,X2,X3} (sampled on accept)
//   in_valid   / in_ready   input handshake (in_ready only in IDLE)
//   dout       result {X35,X34,X33,X32}, held after the output handshake
//   out_valid  / out_ready  output handshake
//   busy       block in RUN or DONE
// ---------------------------------------------------------------------------
module sm4_round_core
   import sm4_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic [1023:0] rk,
   input  logic          mode,
   input  logic [127:0]  din,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [127:0]  dout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);

   localparam logic [4:0] LAST_ROUND = 5'(SM4_ROUNDS - 1);

   sm4_state_t    state_q, state_d;
   logic [4:0]    cnt_q,   cnt_d;
   logic          mode_q,  mode_d;
   logic [127:0]  x_q,     x_d;
   logic [127:0]  dout_q,  dout_d;

   logic [31:0]   x0, x1, x2, x3;
   logic [4:0]    rk_pos;
   logic [31:0]   rk_sel;
   logic [31:0]   t_word;
   logic [31:0]   tau_word;
   logic [31:0]   x_new;

   assign {x0, x1, x2, x3} = x_q;

   // rk word i sits at bit offset (31-i)*32, and 31-i == ~i for 5 bits, so
   // encrypt (rk[cnt]) uses ~cnt and decrypt (rk[31-cnt]) uses cnt directly.
   assign rk_pos = mode_q ? cnt_q : ~cnt_q;
   assign rk_sel = rk[{rk_pos, 5'b0} +: 32];
   assign t_word = x1 ^ x2 ^ x3 ^ rk_sel;

   sm4_tau u_tau (
      .tau_in  (t_word),
      .tau_out (tau_word)
   );

   assign x_new = x0 ^ sm4_l(tau_word);

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      x_d     = x_q;
      dout_d  = dout_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d     = din;
               mode_d  = mode;
               cnt_d   = 5'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            x_d   = {x1, x2, x3, x_new};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_ROUND) begin
               // final state is {X32,X33,X34,X35}; output is its word reversal
               dout_d  = {x_new, x3, x2, x1};
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 5'd0;
         mode_q  <= 1'b0;
         x_q     <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         dout_q  <= dout_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign dout      = dout_q;

endmodule

// File: tb/tb_sm4_round_core.sv
module tb_sm4_round_core;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [1023:0] rk = '0;
   logic          mode = 1'b0;
   logic [127:0]  din = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  dout;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

   localparam logic [7:0] SB [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   logic [31:0] rk_w [32];

   sm4_round_core dut (
      .clk       (clk),
      .rstn      (rstn),
      .rk        (rk),
      .mode      (mode),
      .din       (din),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dout      (dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [31:0] tau_ref(input logic [31:0] v);
      return {SB[v[31:24]], SB[v[23:16]], SB[v[15:8]], SB[v[7:0]]};
   endfunction

   task automatic key_expand(input logic [127:0] key);
      logic [31:0] fk [4];
      logic [31:0] k [36];
      logic [31:0] ck, tmp;
      fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
      for (int i = 0; i < 4; i++) k[i] = key[127 - 32*i -: 32] ^ fk[i];
      for (int i = 0; i < 32; i++) begin
         ck = {8'((4*i) * 7), 8'((4*i + 1) * 7), 8'((4*i + 2) * 7), 8'((4*i + 3) * 7)};
         tmp = tau_ref(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
         k[i+4] = k[i] ^ tmp ^ rotl(tmp, 13) ^ rotl(tmp, 23);
         rk_w[i] = k[i+4];
      end
   endtask

   function automatic logic [127:0] ref_crypt(input logic [127:0] d, input logic m);
      logic [31:0] x [36];
      logic [31:0] tmp, rkv;
      for (int i = 0; i < 4; i++) x[i] = d[127 - 32*i -: 32];
      for (int i = 0; i < 32; i++) begin
         rkv = m ? rk_w[31 - i] : rk_w[i];
         tmp = tau_ref(x[i+1] ^ x[i+2] ^ x[i+3] ^ rkv);
         x[i+4] = x[i] ^ tmp ^ rotl(tmp, 2) ^ rotl(tmp, 10) ^ rotl(tmp, 18) ^ rotl(tmp, 24);
      end
      return {x[35], x[34], x[33], x[32]};
   endfunction

   // ---------------- drivers (called at a negedge) ----------------
   task automatic accept(input logic [127:0] d, input logic m, output int acc_cyc);
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
      end
      in_valid = 1'b1; din = d; mode = m;
      @(negedge clk);
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 100) begin
         total++; bad++;
         $display("FAIL out_valid_timeout: out_valid=%b required=1", out_valid);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid_in_reset: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_in_reset: got %b want 0", busy); end
      rstn = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      total++; if (dout !== 128'h0) begin bad++; $display("FAIL rst_dout: got %h want 0", dout); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
   endtask

   task automatic test_encrypt();
      int a, lat;
      out_ready = 1'b1;
      accept(PT, 1'b0, a);
      total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL enc_run_flags: busy=%b in_ready=%b want 1/0", busy, in_ready); end
      wait_out(lat);
      total++; if (lat !== 32) begin bad++; $display("FAIL enc_latency: got %0d want 32", lat); end
      total++; if (dout !== CT) begin bad++; $display("FAIL enc_vector: got %h want %h", dout, CT); end
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL enc_return_idle: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
      end
      total++; if (dout !== CT) begin bad++; $display("FAIL enc_dout_kept: got %h want %h", dout, CT); end
   endtask

   task automatic test_decrypt();
      int a, lat;
      out_ready = 1'b1;
      accept(CT, 1'b1, a);
      wait_out(lat);
      total++; if (lat !== 32) begin bad++; $display("FAIL dec_latency: got %0d want 32", lat); end
      total++; if (dout !== PT) begin bad++; $display("FAIL dec_vector: got %h want %h", dout, PT); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int a, lat;
      out_ready = 1'b0;
      accept(PT, 1'b0, a);
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         total++; if (dout !== CT) begin bad++; $display("FAIL bp_dout[%0d]: got %h want %h", i, dout, CT); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d]: got %b want 1", i, busy); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
         if (i == 3) begin in_valid = 1'b1; din = 128'hdeadbeef; mode = 1'b1; end
         if (i == 4) in_valid = 1'b0;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      total++; if (dout !== CT) begin bad++; $display("FAIL bp_dout_after: got %h want %h", dout, CT); end
      @(negedge clk);
      total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_pulse_ignored: busy=%b out_valid=%b want 0/0", busy, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int a1, a2, lat;
      logic [127:0] d2 = 128'h00112233445566778899aabbccddeeff;
      out_ready = 1'b1;
      accept(PT, 1'b0, a1);
      wait_out(lat);
      total++; if (dout !== CT) begin bad++; $display("FAIL b2b_first: got %h want %h", dout, CT); end
      accept(d2, 1'b0, a2);
      total++; if (a2 - a1 !== 34) begin bad++; $display("FAIL b2b_spacing: got %0d want 34", a2 - a1); end
      wait_out(lat);
      total++; if (dout !== ref_crypt(d2, 1'b0)) begin bad++; $display("FAIL b2b_second: got %h want %h", dout, ref_crypt(d2, 1'b0)); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int a, lat;
      out_ready = 1'b1;
      accept(PT, 1'b0, a);
      repeat (15) @(negedge clk);
      rstn = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
      total++; if (dout !== 128'h0) begin bad++; $display("FAIL mid_rst_dout: got %h want 0", dout); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
      accept(PT, 1'b0, a);
      wait_out(lat);
      total++; if (dout !== CT) begin bad++; $display("FAIL mid_rst_recover: got %h want %h", dout, CT); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int a, lat, stall;
      logic [127:0] d, exp;
      logic m;
      for (int n = 0; n < 1000; n++) begin
         d   = {$urandom, $urandom, $urandom, $urandom};
         m   = 1'($urandom_range(0, 1));
         exp = ref_crypt(d, m);
         out_ready = 1'b0;
         accept(d, m, a);
         wait_out(lat);
         total++; if (lat !== 32) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want 32", n, lat); end
         stall = $urandom_range(0, 3);
         repeat (stall) @(negedge clk);
         total++; if (dout !== exp) begin bad++; $display("FAIL rnd_dout[%0d] mode=%b: got %h want %h", n, m, dout, exp); end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_dup[%0d]: out_valid=%b want 0", n, out_valid); end
      end
   endtask

   initial begin
      key_expand(KEY);
      for (int i = 0; i < 32; i++) rk[1023 - 32*i -: 32] = rk_w[i];
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

endmodule
